// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM data-memory controller: defaults, widths, FSM states.
package sram_controller_pkg;

  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam int unsigned HALF_W          = 16;
  localparam int unsigned WORD_W          = 32;

  // Word transfer sequencing: low half, then high half, then one ready cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-half-word wait counter: counts 0..WAIT_CYCLES-1, done flags the terminal count.
module sram_wait_counter
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data-memory controller: splits each 32-bit access into two 16-bit
// asynchronous SRAM accesses (low half first) and holds ready low until done.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
);

  localparam int unsigned IDX_W = SRAM_ADDR_W - 1;

  state_e                   state_q, state_d;
  logic                     op_wr_q, op_wr_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [WORD_W-1:0]        wdata_q, wdata_d;
  logic [WORD_W-1:0]        rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0]   addr_q, addr_d;
  logic                     we_n_q, we_n_d;
  logic                     oe_q, oe_d;
  logic [HALF_W-1:0]        dq_q, dq_d;

  logic [WORD_W-1:0]        off_c;
  logic [IDX_W-1:0]         req_idx_c;
  logic                     cnt_clear_c;
  logic                     cnt_done_c;
  logic                     unused_off_c;

  // Word index relative to the SRAM window; upper bits wrap, byte offset ignored.
  assign off_c        = address - WORD_W'(BASE_ADDR);
  assign req_idx_c    = off_c[IDX_W+1:2];
  assign unused_off_c = ^{off_c[WORD_W-1:IDX_W+2], off_c[1:0]};

  // Wait counter restarts outside the access states and at each half-word boundary.
  assign cnt_clear_c = (state_q == ST_IDLE) || (state_q == ST_DONE) || cnt_done_c;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear_c),
    .done  (cnt_done_c)
  );

  // Next state and next SRAM pin values; pins are registered so they are
  // computed for the state being entered.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    we_n_d  = 1'b1;
    oe_d    = 1'b0;
    dq_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          op_wr_d = wr_en;
          idx_d   = req_idx_c;
          wdata_d = write_data;
          state_d = ST_LOW;
          addr_d  = {req_idx_c, 1'b0};
          if (wr_en) begin
            we_n_d = 1'b0;
            oe_d   = 1'b1;
            dq_d   = write_data[15:0];
          end
        end
      end
      ST_LOW: begin
        if (cnt_done_c) begin
          if (!op_wr_q) begin
            rdata_d[15:0] = sram_dq_in;
          end
          state_d = ST_HIGH;
          addr_d  = {idx_q, 1'b1};
          if (op_wr_q) begin
            we_n_d = 1'b0;
            oe_d   = 1'b1;
            dq_d   = wdata_q[31:16];
          end
        end else begin
          addr_d = {idx_q, 1'b0};
          if (op_wr_q) begin
            we_n_d = 1'b0;
            oe_d   = 1'b1;
            dq_d   = wdata_q[15:0];
          end
        end
      end
      ST_HIGH: begin
        if (cnt_done_c) begin
          if (!op_wr_q) begin
            rdata_d[31:16] = sram_dq_in;
          end
          state_d = ST_DONE;
        end else if (op_wr_q) begin
          we_n_d = 1'b0;
          oe_d   = 1'b1;
          dq_d   = wdata_q[31:16];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request and SRAM pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dq_q    <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      we_n_q  <= we_n_d;
      oe_q    <= oe_d;
      dq_q    <= dq_d;
    end
  end

  // Pipeline stall: low while a request is pending and not yet in its done cycle.
  assign ready       = ~(rd_en | wr_en) | (state_q == ST_DONE);
  assign read_data   = rdata_q;
  assign sram_addr   = addr_q;
  assign sram_we_n   = we_n_q;
  assign sram_dq_out = dq_q;
  assign sram_dq_oe  = oe_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed scoreboard bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;

  localparam int unsigned W     = 2;
  localparam int unsigned AW    = 18;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en, wr_en;
  logic [31:0]   address, write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic          sram_we_n;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;

  logic [15:0]   mem [0:DEPTH-1];
  logic [31:0]   shadow [int unsigned];
  logic [31:0]   sb_q [$];

  int            errors = 0;
  int            checks = 0;
  int            strobes = 0;
  int            viol = 0;
  bit            reading = 1'b0;

  sram_controller #(
    .BASE_ADDR   (1024),
    .WAIT_CYCLES (W),
    .SRAM_ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_we_n   (sram_we_n),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write while we_n is low.
  assign sram_dq_in = mem[sram_addr];

  always @(posedge clk) begin
    if (sram_we_n === 1'b0) begin
      mem[sram_addr] <= sram_dq_out;
      strobes <= strobes + 1;
    end
  end

  always @(negedge clk) begin
    if (reading && sram_we_n !== 1'b1) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word access from the IDLE cycle; checks every cycle through the ready cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int unsigned exp_idx, input int drop_at);
    logic          iswr;
    logic [AW-1:0] lo, hi;
    logic [31:0]   exp_rd;
    iswr = wr;
    lo   = AW'(exp_idx * 2);
    hi   = AW'(exp_idx * 2 + 1);
    if (iswr) shadow[exp_idx] = wd;
    else      sb_q.push_back(shadow[exp_idx]);
    reading    = !iswr;
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = wd;
    for (int c = 0; c <= 2 * W + 1; c++) begin
      if (c == drop_at) begin
        rd_en = 1'b0;
        wr_en = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("ready_c%0d", c), 32'(ready),
          ((c == 2 * W + 1) || !(rd_en | wr_en)) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 2 * W) begin
        chk($sformatf("addr_c%0d", c), 32'(sram_addr), (c <= W) ? 32'(lo) : 32'(hi));
        chk($sformatf("we_n_c%0d", c), 32'(sram_we_n), iswr ? 32'd0 : 32'd1);
        chk($sformatf("oe_c%0d", c), 32'(sram_dq_oe), iswr ? 32'd1 : 32'd0);
        if (iswr)
          chk($sformatf("dq_out_c%0d", c), 32'(sram_dq_out),
              (c <= W) ? 32'(wd[15:0]) : 32'(wd[31:16]));
      end
      if (c == 2 * W + 1) begin
        chk("we_n_done", 32'(sram_we_n), 32'd1);
        chk("oe_done", 32'(sram_dq_oe), 32'd0);
        if (!iswr) begin
          exp_rd = sb_q.pop_front();
          chk("read_data", read_data, exp_rd);
        end
      end
      @(posedge clk);
      #1;
    end
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    reading = 1'b0;
  endtask

  initial begin
    int s;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Store then check SRAM contents
    run_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1, -1);
    chk("mem2", 32'(mem[2]), 32'h0000BEEF);
    chk("mem3", 32'(mem[3]), 32'h0000DEAD);

    // Load of preset SRAM contents
    mem[2] = 16'h5678; mem[3] = 16'h1234; shadow[1] = 32'h12345678;
    run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1, -1);

    // Back-to-back store then load, same address
    run_txn(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 2, -1);
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 2, -1);

    // Both enables: write wins, read_data untouched by writes
    run_txn(1'b1, 1'b1, 32'd1037, 32'h0BADC0DE, 3, -1);
    chk("rdata_hold", read_data, 32'hCAFEF00D);
    run_txn(1'b1, 1'b0, 32'd1036, 32'h0, 3, -1);

    // Drop rd_en in cycle 2; sequence completes, then a normal access follows
    run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1, 2);
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 2, -1);

    // Reset in cycle 3 of a write
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    s = strobes;
    @(negedge clk);
    chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("mid_rst_read_data", read_data, 32'h0);
    chk("mid_rst_addr", 32'(sram_addr), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_no_strobe", 32'(strobes), 32'(s));
    run_txn(1'b1, 1'b0, 32'd1028, 32'h0, 1, -1);

    // Wrap at the top of the SRAM window
    run_txn(1'b0, 1'b1, 32'd1024 + 32'd4 * (32'd1 << (AW - 1)), 32'hA5A55A5A, 0, -1);
    chk("wrap_mem0", 32'(mem[0]), 32'h00005A5A);
    chk("wrap_mem1", 32'(mem[1]), 32'h0000A5A5);
    run_txn(1'b1, 1'b0, 32'd1024 + 32'd4 * (32'd1 << (AW - 1)), 32'h0, 0, -1);

    chk("read_strobe_viol", 32'(viol), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
